knn_ctrl: RTL and testbench
===========================

KNN_CTRL -- requirements
Module: knn_ctrl

Interface
REQ-001 Parameter DATA_W, 32, packed point width: x in [31:16], y in [15:0].
REQ-002 Parameter LABEL, 8, label width.
REQ-003 Parameter N_NEIGHBOUR, 10, neighbour list depth of the KNN core.
REQ-004 Parameter ADDR_W, 10, training/test memory address width.
REQ-005 clk  in  1  clock.
REQ-006 rst  in  1  reset: asynchronous, active-high.
REQ-007 run  in  1  start-of-job pulse.
REQ-008 abort  in  1  synchronous job cancel.
REQ-009 n_train  in  ADDR_W  training point count.
REQ-010 n_test  in  ADDR_W  test point count.
REQ-011 train_rd_en / train_addr  out  1 / ADDR_W  training memory read; train_data (DATA_W) and train_label (LABEL) in, 1-cycle latency.
REQ-012 test_rd_en / test_addr  out  1 / ADDR_W  test memory read; test_data in, DATA_W, 1-cycle latency.
REQ-013 core_A, core_B  out  DATA_W  test point / training point to the KNN core.
REQ-014 core_label  out  LABEL  training label to the core.
REQ-015 core_start, core_valid  out  1  core list clear / candidate strobe.
REQ-016 neighbour_info  in  LABEL*N_NEIGHBOUR  core neighbour labels.
REQ-017 res_valid  out  1, res_ready  in  1  result handshake.
REQ-018 res_idx  out  ADDR_W, res_info  out  LABEL*N_NEIGHBOUR  test index and captured neighbour labels.
REQ-019 busy  out  1, done  out  1  job active / one-cycle completion pulse.

Function
REQ-020 FSM states SHALL be IDLE, LOAD, START, STREAM, DRAIN, RESULT; all outputs registered.
REQ-021 IDLE: run=1 with n_train>=1 and n_test>=1 SHALL latch both counts, clear test index t and enter LOAD; busy=1 from next cycle.
REQ-022 IDLE: run=1 with either count 0 SHALL pulse done next cycle, no memory reads, no results.
REQ-023 run while not IDLE SHALL be ignored; latched counts SHALL not change mid-job.
REQ-024 LOAD (1 cycle): test_rd_en=1, test_addr=t.
REQ-025 START (1 cycle): core_A<=test_data, core_start=1, train_rd_en=1, train_addr=0; core_A SHALL then hold until next START.
REQ-026 STREAM lasts exactly n_train cycles; in cycle j core_valid=1, core_B/core_label = data of address j; train_rd_en=1 with train_addr=j+1 only when j+1<n_train.
REQ-027 core_valid and core_start SHALL never be high in the same cycle.
REQ-028 DRAIN (1 cycle): core_valid=0; at its end res_info<=neighbour_info, res_idx<=t.
REQ-029 RESULT: res_valid=1, res_info/res_idx stable until res_valid&res_ready sampled.
REQ-030 On handshake: if t+1<n_test, t<=t+1 and go LOAD; else go IDLE, busy=0 and done=1 for one cycle.
REQ-031 Latency: run sampled at cycle 0 -> first res_valid at cycle n_train+4; following results every n_train+4 cycles with res_ready held high.
REQ-032 res_ready while res_valid=0 SHALL be ignored.
REQ-033 abort=1 in any non-IDLE state SHALL return to IDLE next cycle with all strobes and res_valid low, busy=0, no done pulse; abort has priority over res_ready and run.
REQ-034 n_train up to 2^ADDR_W-1 SHALL stream without counter wrap; t and j counters are ADDR_W bits.

Reset
REQ-035 rst=1 SHALL force IDLE asynchronously and zero all outputs, counters, latched counts, core_A, core_B, res_info, res_idx.
REQ-036 rst asserted mid-job SHALL discard the job; after release the block SHALL await a new run.

Verification
REQ-037 n_train=3, n_test=1, run at cycle 0, res_ready=1 -> core_start at cycle 2, core_valid cycles 3-5 with addresses 0,1,2, res_valid at cycle 7, done at cycle 8.
REQ-038 n_train=2, n_test=3, res_ready=1 -> res_idx 0,1,2 at cycles 6,12,18; one done pulse after the third.
REQ-039 res_ready low for 5 cycles in RESULT -> res_valid and res_info held, no new LOAD until handshake.
REQ-040 n_test=0 with run -> done pulse at cycle 1, train_rd_en and test_rd_en never asserted.
REQ-041 abort in STREAM at j=1 -> IDLE next cycle, core_valid low, no done; new run restarts at t=0.
REQ-042 rst pulse mid-STREAM -> all outputs 0 immediately; run ignored while rst=1.

Source files
------------

// File: rtl/knn_ctrl.sv
// knn_ctrl: sequences test/training memory reads into a KNN core
// and returns each test point's captured neighbour labels.
module knn_ctrl #(
  parameter int DATA_W      = 32,
  parameter int LABEL       = 8,
  parameter int N_NEIGHBOUR = 10,
  parameter int ADDR_W      = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         run,
  input  logic                         abort,
  input  logic [ADDR_W-1:0]            n_train,
  input  logic [ADDR_W-1:0]            n_test,
  output logic                         train_rd_en,
  output logic [ADDR_W-1:0]            train_addr,
  input  logic [DATA_W-1:0]            train_data,
  input  logic [LABEL-1:0]             train_label,
  output logic                         test_rd_en,
  output logic [ADDR_W-1:0]            test_addr,
  input  logic [DATA_W-1:0]            test_data,
  output logic [DATA_W-1:0]            core_A,
  output logic [DATA_W-1:0]            core_B,
  output logic [LABEL-1:0]             core_label,
  output logic                         core_start,
  output logic                         core_valid,
  input  logic [LABEL*N_NEIGHBOUR-1:0] neighbour_info,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [ADDR_W-1:0]            res_idx,
  output logic [LABEL*N_NEIGHBOUR-1:0] res_info,
  output logic                         busy,
  output logic                         done
);

  typedef enum logic [2:0] {
    IDLE, LOAD, START, STREAM, DRAIN, RESULT
  } state_t;

  state_t state, state_d;

  logic [ADDR_W-1:0] nt_q, ns_q;
  logic [ADDR_W-1:0] t_q, t_d;
  logic [ADDR_W-1:0] j_q, j_d;
  logic go, empty, last_t, last_j;

  logic              test_rd_en_d, train_rd_en_d;
  logic              core_start_d, core_valid_d;
  logic              res_valid_d, busy_d, done_d;
  logic [ADDR_W-1:0] test_addr_d, train_addr_d;

  assign go     = run && (n_train != '0) && (n_test != '0);
  assign empty  = run && ((n_train == '0) || (n_test == '0));
  assign last_t = (t_q == ns_q - 1'b1);
  assign last_j = (j_q == nt_q - 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      nt_q  <= '0;
      ns_q  <= '0;
      t_q   <= '0;
      j_q   <= '0;
    end else begin
      state <= state_d;
      t_q   <= t_d;
      j_q   <= j_d;
      if (state == IDLE && go) begin
        nt_q <= n_train;
        ns_q <= n_test;
      end
    end
  end

  always_comb begin
    state_d = state;
    t_d     = t_q;
    j_d     = j_q;
    unique case (state)
      IDLE: if (go) begin
        state_d = LOAD;
        t_d     = '0;
      end
      LOAD:  state_d = START;
      START: begin
        state_d = STREAM;
        j_d     = '0;
      end
      STREAM: begin
        j_d = j_q + 1'b1;
        if (last_j) state_d = DRAIN;
      end
      DRAIN: state_d = RESULT;
      RESULT: if (res_ready) begin
        if (last_t) state_d = IDLE;
        else begin
          state_d = LOAD;
          t_d     = t_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort && state != IDLE) state_d = IDLE;
  end

  // Strobes are derived from the next state so they register in step with it.
  always_comb begin
    test_rd_en_d  = (state_d == LOAD);
    test_addr_d   = test_rd_en_d ? t_d : '0;
    core_start_d  = (state_d == START);
    core_valid_d  = (state_d == STREAM);
    train_rd_en_d = core_start_d ||
                    (core_valid_d && (j_d < nt_q - 1'b1));
    train_addr_d  = '0;
    if (core_valid_d && train_rd_en_d)
      train_addr_d = j_d + 1'b1;
    res_valid_d   = (state_d == RESULT);
    busy_d        = (state_d != IDLE);
    done_d        = (state == IDLE && empty) ||
                    (state == RESULT && res_ready && last_t && !abort);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      test_rd_en  <= 1'b0;
      test_addr   <= '0;
      train_rd_en <= 1'b0;
      train_addr  <= '0;
      core_start  <= 1'b0;
      core_valid  <= 1'b0;
      res_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      core_A      <= '0;
      res_idx     <= '0;
      res_info    <= '0;
    end else begin
      test_rd_en  <= test_rd_en_d;
      test_addr   <= test_addr_d;
      train_rd_en <= train_rd_en_d;
      train_addr  <= train_addr_d;
      core_start  <= core_start_d;
      core_valid  <= core_valid_d;
      res_valid   <= res_valid_d;
      busy        <= busy_d;
      done        <= done_d;
      if (state == START) core_A <= test_data;
      if (state == DRAIN) begin
        res_idx  <= t_q;
        res_info <= neighbour_info;
      end
    end
  end

  // Read data lands in the same cycle as its core_valid strobe, so the
  // candidate is forwarded straight from the memory port, gated to zero.
  assign core_B     = core_valid ? train_data  : '0;
  assign core_label = core_valid ? train_label : '0;

endmodule

// File: tb/tb_knn_ctrl.sv
// tb_knn_ctrl: randomized self-checking bench for knn_ctrl
// against a cycle-offset timeline model of each job.
module tb_knn_ctrl;
  localparam int DW = 32;
  localparam int LW = 8;
  localparam int NN = 10;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst, run, abort, res_ready;
  logic [AW-1:0] n_train, n_test;
  logic train_rd_en, test_rd_en;
  logic [AW-1:0] train_addr, test_addr;
  logic [DW-1:0] train_data, test_data;
  logic [LW-1:0] train_label;
  logic [DW-1:0] core_A, core_B;
  logic [LW-1:0] core_label;
  logic core_start, core_valid;
  logic [LW*NN-1:0] neighbour_info, res_info;
  logic res_valid, busy, done;
  logic [AW-1:0] res_idx;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] train_mem [1024];
  logic [LW-1:0] label_mem [1024];
  logic [DW-1:0] test_mem  [1024];

  logic [188:0] all_o;
  logic [6:0]   act_s;
  assign all_o = {train_rd_en, train_addr, test_rd_en, test_addr,
                  core_A, core_B, core_label, core_start, core_valid,
                  res_valid, res_idx, res_info, busy, done};
  assign act_s = {test_rd_en, core_start, train_rd_en, core_valid,
                  res_valid, busy, done};

  knn_ctrl #(.DATA_W(DW), .LABEL(LW), .N_NEIGHBOUR(NN), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .run(run), .abort(abort),
    .n_train(n_train), .n_test(n_test),
    .train_rd_en(train_rd_en), .train_addr(train_addr),
    .train_data(train_data), .train_label(train_label),
    .test_rd_en(test_rd_en), .test_addr(test_addr), .test_data(test_data),
    .core_A(core_A), .core_B(core_B), .core_label(core_label),
    .core_start(core_start), .core_valid(core_valid),
    .neighbour_info(neighbour_info),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_idx(res_idx), .res_info(res_info),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (train_rd_en) begin
      train_data  <= train_mem[train_addr];
      train_label <= label_mem[train_addr];
    end
    if (test_rd_en) test_data <= test_mem[test_addr];
  end

  // Job timeline: a test starting its LOAD at cycle s has START at s+1,
  // candidate j at s+2+j, DRAIN at s+2+nt, result from s+3+nt on.
  task automatic check_job(input int nt, input int ns, input int rmode,
                           input int abort_off, input bit rand_run,
                           input string name);
    int s, t, c, o, lowcnt;
    bit fin, stop;
    bit te, cs, tr, cv, rv;
    logic [6:0] exp_s;
    logic [LW*NN-1:0] exp_info;
    exp_info = '0;
    @(negedge clk);
    n_train = AW'(nt);
    n_test  = AW'(ns);
    run = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    run = 1'b0;
    s = 1; t = 0; c = 1; lowcnt = 0;
    fin = 0; stop = 0;
    while (!fin && !stop && c < 5000) begin
      o  = c - s;
      te = (o == 0);
      cs = (o == 1);
      cv = (o >= 2) && (o <= nt + 1);
      tr = cs || (cv && (o - 1 < nt));
      rv = (o >= nt + 3);
      exp_s = {te, cs, tr, cv, rv, 1'b1, 1'b0};
      checks++;
      if (act_s !== exp_s) begin
        errors++;
        $display("FAIL %s strobes c=%0d t=%0d got=%b want=%b",
                 name, c, t, act_s, exp_s);
      end
      if (te) begin
        checks++;
        if (test_addr !== AW'(t)) begin
          errors++;
          $display("FAIL %s test_addr got=%0d want=%0d", name, test_addr, t);
        end
      end
      if (tr) begin
        checks++;
        if (train_addr !== AW'(cs ? 0 : o - 1)) begin
          errors++;
          $display("FAIL %s train_addr c=%0d got=%0d want=%0d",
                   name, c, train_addr, cs ? 0 : o - 1);
        end
      end
      if (cv) begin
        checks++;
        if ({core_A, core_B, core_label} !==
            {test_mem[t], train_mem[o-2], label_mem[o-2]}) begin
          errors++;
          $display("FAIL %s core data j=%0d got=%h/%h/%h want=%h/%h/%h",
                   name, o - 2, core_A, core_B, core_label,
                   test_mem[t], train_mem[o-2], label_mem[o-2]);
        end
      end
      if (rv) begin
        checks++;
        if ({res_idx, res_info} !== {AW'(t), exp_info}) begin
          errors++;
          $display("FAIL %s result got=%0d/%h want=%0d/%h",
                   name, res_idx, res_info, t, exp_info);
        end
      end
      neighbour_info = (LW*NN)'({$urandom, $urandom, $urandom});
      if (o == nt + 2) exp_info = neighbour_info;
      if (rmode == 0) res_ready = 1'b1;
      else if (rmode == 2 && rv) begin
        res_ready = (lowcnt >= 5);
        lowcnt++;
      end else res_ready = 1'($urandom);
      if (rand_run) begin
        run     = 1'($urandom);
        n_train = AW'($urandom);
        n_test  = AW'($urandom);
      end
      if (t == 0 && o == abort_off) begin
        abort = 1'b1;
        stop  = 1;
      end else if (rv && res_ready) begin
        if (t + 1 < ns) begin
          t++;
          s = c + 1;
          lowcnt = 0;
        end else fin = 1;
      end
      @(negedge clk);
      c++;
    end
    abort = 1'b0;
    run   = 1'b0;
    if (stop) begin
      checks++;
      if (act_s !== 7'b0) begin
        errors++;
        $display("FAIL %s after abort got=%b want=0000000", name, act_s);
      end
    end else if (fin) begin
      checks++;
      if (act_s !== 7'b0000001) begin
        errors++;
        $display("FAIL %s done cycle got=%b want=0000001", name, act_s);
      end
      @(negedge clk);
      checks++;
      if (act_s !== 7'b0) begin
        errors++;
        $display("FAIL %s after done got=%b want=0000000", name, act_s);
      end
    end else begin
      checks++;
      errors++;
      $display("FAIL %s timeout got=no_done want=done", name);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; run = 1'b0; abort = 1'b0; res_ready = 1'b0;
    n_train = '0; n_test = '0; neighbour_info = '0;
    #1;
    checks++;
    if (all_o !== '0) begin
      errors++;
      $display("FAIL reset outputs got=%h want=0", all_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (all_o !== '0) begin
      errors++;
      $display("FAIL reset idle got=%h want=0", all_o);
    end
  endtask

  task automatic test_empty(input int nt, input int ns);
    @(negedge clk);
    n_train = AW'(nt); n_test = AW'(ns); run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    checks++;
    if (act_s !== 7'b0000001) begin
      errors++;
      $display("FAIL empty done nt=%0d ns=%0d got=%b want=0000001",
               nt, ns, act_s);
    end
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (act_s !== 7'b0) begin
        errors++;
        $display("FAIL empty quiet got=%b want=0000000", act_s);
      end
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    n_train = 6; n_test = 2; run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    run = 1'b1;
    #1;
    checks++;
    if (all_o !== '0) begin
      errors++;
      $display("FAIL rst_mid async got=%h want=0", all_o);
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (all_o !== '0) begin
        errors++;
        $display("FAIL rst_mid held got=%h want=0", all_o);
      end
    end
    rst = 1'b0;
    run = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (all_o !== '0) begin
        errors++;
        $display("FAIL rst_mid idle got=%h want=0", all_o);
      end
    end
  endtask

  task automatic test_random;
    repeat (4)
      check_job(int'($urandom_range(1, 12)), int'($urandom_range(1, 4)),
                1, -1, 1, "random");
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      train_mem[i] = $urandom;
      label_mem[i] = LW'($urandom);
      test_mem[i]  = $urandom;
    end
    test_reset;
    check_job(3, 1, 0, -1, 0, "basic");
    check_job(2, 3, 0, -1, 0, "multi");
    check_job(4, 2, 2, -1, 1, "hold");
    test_empty(5, 0);
    test_empty(0, 3);
    test_random;
    check_job(5, 2, 0, 3, 0, "abort_stream");
    check_job(3, 2, 0, -1, 0, "after_abort");
    check_job(2, 2, 0, 5, 0, "abort_result");
    test_reset_mid;
    check_job(4, 2, 1, -1, 0, "after_rst");
    check_job(1, 2, 0, -1, 0, "single_train");
    check_job(1023, 1, 0, -1, 0, "long");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
